camera_capture: RTL and testbench
=================================

# camera_capture

Frame-capture front end for the image-filter pipeline. It drives `camera_en` on the camera source and samples its `data_valid`/`data_out` stream, which the camera updates on the falling edge. It buffers accepted bytes in a small FIFO and re-emits them as a ready/valid pixel stream, tagged with x/y coordinates and start-of-frame/end-of-line flags. Exactly one frame of `IMG_W*IMG_H` pixels is captured per `start`.

## Interface
- `IMG_W`, 8: pixels per line; range 1..256.
- `IMG_H`, 8: lines per frame; range 1..256.
- `FIFO_DEPTH`, 4: capture FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: clock. All state is on the rising edge. The camera updates on the falling edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to capture one frame. Ignored unless idle.
- `cam_valid` in 1: camera `data_valid`.
- `cam_data` in 8: camera `data_out`. Don't-care (may be Z) when `cam_valid`=0.
- `camera_en` out 1: camera enable. Registered.
- `busy` out 1: high from the cycle after accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the last pixel handshake.
- `pix_valid` out 1: FIFO non-empty.
- `pix_ready` in 1: downstream accept.
- `pix_data` out 8: FIFO head byte.
- `pix_x` out 8: column of the head pixel.
- `pix_y` out 8: row of the head pixel.
- `pix_sof` out 1: head is pixel (0,0).
- `pix_eol` out 1: head is the last pixel of a line (`pix_x`==`IMG_W-1`).
- `err` out 1: sticky protocol error. Present only with `CAM_CAPTURE_ERR_EN`.

## Operation
- State machine IDLE → CAPTURE → DRAIN → IDLE. `TOTAL = IMG_W*IMG_H`; counters are 17 bits wide.
- IDLE: on `start`=1, clear `recv_cnt` and `out_cnt`, go to CAPTURE.
- Write rule: at each rising edge, if `cam_valid`=1 and `camera_en`=1, push `cam_data` and increment `recv_cnt`. Beats with `camera_en`=0 are discarded.
- `camera_en` next value = 1 iff all of the following hold:
  - next state is CAPTURE;
  - `recv_cnt_next` < TOTAL;
  - `fifo_count_next` < FIFO_DEPTH.
  - This rule guarantees a write never meets a full FIFO and that no more than TOTAL bytes are requested.
- A missing beat (`camera_en`=1, `cam_valid`=0) writes nothing; the request is re-issued on a later cycle.
- CAPTURE → DRAIN when `recv_cnt_next` == TOTAL.
- Pop rule: a pop occurs when `pix_valid`=1 and `pix_ready`=1. On each pop:
  - increment `out_cnt`;
  - advance `pix_x`; when it wraps from `IMG_W-1` to 0, advance `pix_y`.
- Simultaneous push and pop: `fifo_count` is unchanged. Push into an empty FIFO with a simultaneous pop is not possible, since `pix_valid` was 0.
- DRAIN → IDLE on the pop that makes `out_cnt` == TOTAL. `done` is asserted for the following cycle; `pix_x`/`pix_y` return to 0.
- `start` during CAPTURE or DRAIN is ignored.
- The frame size is fixed at TOTAL. There is no abort other than `rst_n`.

## Timing
- Reset values:
  - `camera_en`, `busy`, `done`, `pix_valid` = 0;
  - `pix_x`, `pix_y` = 0;
  - FIFO empty; state IDLE;
  - `err` = 0.
- Reset mid-frame clears everything immediately; `camera_en` drops asynchronously. A camera beat in flight is lost.
- `start` in cycle 0 gives:
  - `busy`=1 and `camera_en`=1 in cycle 1;
  - the first byte sampled at the end of cycle 1;
  - `pix_valid`=1 in cycle 2.
- With `pix_ready` held at 1 and the camera always valid:
  - one pixel per cycle;
  - `camera_en` high for exactly TOTAL consecutive cycles;
  - `done` in cycle TOTAL+2.
- `pix_data`, `pix_x`, `pix_y`, `pix_sof` and `pix_eol` are stable while `pix_valid`=1 and `pix_ready`=0.

## Configuration
- `CAM_CAPTURE_ERR_EN` defined:
  - adds the `err` port;
  - `err` sets when `cam_valid`=1 while `camera_en`=0 and the state is not IDLE (unrequested beat);
  - `err` also sets when `cam_valid`=0 while `camera_en`=1 (missing beat);
  - `err` clears only on reset or on an accepted `start`.
- `CAM_CAPTURE_ERR_EN` not defined: no `err` port and no detection logic. Data-path behaviour is identical in both builds.

## Test plan
All scenarios use `IMG_W`=4, `IMG_H`=2.
- Free-running, ready=1, camera sending 0x10..0x17: 8 pixels out in order; (x,y) = (0,0)…(3,1); `pix_sof` on 0x10 only; `pix_eol` on 0x13 and 0x17; `done` one cycle; `camera_en` high for exactly 8 cycles.
- `pix_ready`=0 after `start`: `camera_en` drops after 4 beats, FIFO holds 0x10..0x13, head stable. Releasing ready lets the remaining 4 bytes flow; no loss or duplication.
- Camera drops `cam_valid` for 2 cycles mid-frame: still exactly 8 pixels and `done`; with `CAM_CAPTURE_ERR_EN`, `err`=1.
- `start` pulsed again during CAPTURE: ignored; a single frame of 8 pixels is produced.
- `rst_n` low after 3 pixels: all outputs reach reset values immediately. A new `start` captures a full fresh frame beginning at (0,0).
- `cam_valid`=1 while idle (camera held enabled externally): no pixels emitted; with `CAM_CAPTURE_ERR_EN`, `err` stays 0 in IDLE.

Source files
------------

// File: rtl/camera_capture.sv
// Single-frame camera capture: requests bytes from the camera, buffers them in a small FIFO and
// re-emits them as a coordinate-tagged ready/valid stream. Define CAM_CAPTURE_ERR_EN for the err port.
module camera_capture #(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cam_valid,
  input  logic [7:0] cam_data,
  output logic       camera_en,
  output logic       busy,
  output logic       done,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [7:0] pix_data,
  output logic [7:0] pix_x,
  output logic [7:0] pix_y,
  output logic       pix_sof,
`ifdef CAM_CAPTURE_ERR_EN
  output logic       err,
`endif
  output logic       pix_eol
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [16:0]   TOTAL   = 17'(IMG_W * IMG_H);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [7:0]    X_LAST  = 8'(IMG_W - 1);
  localparam logic [7:0]    Y_LAST  = 8'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

  state_t        r_state, w_state_next;
  logic [16:0]   r_recv_cnt, r_out_cnt, w_recv_next, w_out_next;
  logic [CW-1:0] r_count, w_count_next;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic          r_camera_en, r_busy, r_done;
  logic [7:0]    r_pix_x, r_pix_y;
  logic          w_push, w_pop, w_start, w_en_next;

  assign w_push  = cam_valid & r_camera_en;
  assign w_pop   = (r_count != '0) & pix_ready;
  assign w_start = start & (r_state == S_IDLE);

  // The enable is computed from next-cycle counts so a granted beat always has FIFO room.
  always_comb begin
    w_recv_next  = w_start ? '0 : r_recv_cnt + {16'd0, w_push};
    w_out_next   = w_start ? '0 : r_out_cnt + {16'd0, w_pop};
    w_count_next = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_state_next = S_CAPTURE;
      S_CAPTURE: if (w_recv_next == TOTAL) w_state_next = S_DRAIN;
      S_DRAIN:   if (w_pop && (w_out_next == TOTAL)) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
    w_en_next = (w_state_next == S_CAPTURE) && (w_recv_next < TOTAL) && (w_count_next < DEPTH_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_recv_cnt  <= '0;
      r_out_cnt   <= '0;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_camera_en <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_recv_cnt  <= w_recv_next;
      r_out_cnt   <= w_out_next;
      r_count     <= w_count_next;
      r_camera_en <= w_en_next;
      r_busy      <= (w_state_next != S_IDLE);
      r_done      <= (r_state == S_DRAIN) && (w_state_next == S_IDLE);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_start) begin
        r_pix_x <= '0;
        r_pix_y <= '0;
      end else if (w_pop) begin
        if (r_pix_x == X_LAST) begin
          r_pix_x <= '0;
          r_pix_y <= (r_pix_y == Y_LAST) ? 8'd0 : r_pix_y + 8'd1;
        end else begin
          r_pix_x <= r_pix_x + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= cam_data;
  end

`ifdef CAM_CAPTURE_ERR_EN
  logic r_err;

  // Sticky: unrequested beat outside IDLE, or a requested beat the camera did not deliver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_start) begin
      r_err <= 1'b0;
    end else if ((cam_valid && !r_camera_en && (r_state != S_IDLE)) || (!cam_valid && r_camera_en)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

  assign camera_en = r_camera_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pix_valid = (r_count != '0);
  assign pix_data  = r_mem[r_rd_ptr];
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_sof   = pix_valid && (r_pix_x == 8'd0) && (r_pix_y == 8'd0);
  assign pix_eol   = pix_valid && (r_pix_x == X_LAST);

endmodule

// File: tb/tb_camera_capture.sv
// Scoreboard bench for camera_capture at IMG_W=4, IMG_H=2; checks err when CAM_CAPTURE_ERR_EN is defined.
module tb_camera_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cam_valid = 1'b0;
  logic [7:0] cam_data = 8'h00;
  logic       pix_ready = 1'b0;
  logic       camera_en, busy, done, pix_valid, pix_sof, pix_eol;
  logic [7:0] pix_data, pix_x, pix_y;
`ifdef CAM_CAPTURE_ERR_EN
  logic       err;
`endif

  int tests = 0;
  int fails = 0;
  int popCount = 0;
  int enCount = 0;
  int sentIdx = 0;
  int dropLeft = 0;
  bit dropArm = 1'b0;
  bit forceValid = 1'b0;
  logic [7:0] frameBase = 8'h10;
  logic [25:0] sb[$];

  camera_capture #(.IMG_W(4), .IMG_H(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cam_valid(cam_valid), .cam_data(cam_data),
    .camera_en(camera_en), .busy(busy), .done(done), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof),
`ifdef CAM_CAPTURE_ERR_EN
    .err(err),
`endif
    .pix_eol(pix_eol)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Camera model: updates on the falling edge, answering whatever camera_en requests.
  always @(negedge clk) begin
    if (forceValid) begin
      cam_valid = 1'b1;
      cam_data  = 8'hAA;
    end else if (camera_en && dropArm && dropLeft > 0 && sentIdx == 3) begin
      cam_valid = 1'b0;
      dropLeft--;
    end else if (camera_en) begin
      cam_valid = 1'b1;
      cam_data  = frameBase + 8'(sentIdx);
    end else begin
      cam_valid = 1'b0;
    end
  end

  always @(posedge clk) if (cam_valid && camera_en) sentIdx++;
  always @(negedge clk) if (camera_en) enCount++;

  // Monitor: every handshake pops one expected pixel.
  always @(negedge clk) begin
    if (rst_n && pix_valid && pix_ready) begin
      popCount++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_pixel: got data 0x%0h, expected no pixel", pix_data);
      end else begin
        checkOutput("pixel", {6'd0, pix_data, pix_x, pix_y, pix_sof, pix_eol}, {6'd0, sb.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulses start for one cycle and queues the eight expected pixels of the frame.
  task automatic applyStimulus(input logic [7:0] base);
    frameBase = base;
    sentIdx   = 0;
    for (int i = 0; i < 8; i++)
      sb.push_back({base + 8'(i), 8'(i % 4), 8'(i / 4), (i == 0), (i % 4 == 3)});
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic waitDone(output int cyc);
    cyc = 1;
    while (!done && cyc < 200) begin
      tick(1);
      cyc++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 200 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, p0;

    tick(2);
    checkOutput("rst_camera_en", camera_en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pix_valid", pix_valid, 0);
    checkOutput("rst_pix_xy", {pix_x, pix_y}, 0);
`ifdef CAM_CAPTURE_ERR_EN
    checkOutput("rst_err", err, 0);
`endif
    rst_n = 1'b1;
    tick(2);

    // Free-running frame
    pix_ready = 1'b1;
    enCount = 0;
    p0 = popCount;
    applyStimulus(8'h10);
    checkOutput("t1_busy_c1", busy, 1);
    checkOutput("t1_en_c1", camera_en, 1);
    checkOutput("t1_valid_c1", pix_valid, 0);
    tick(1);
    checkOutput("t1_valid_c2", pix_valid, 1);
    cyc = 2;
    while (!done && cyc < 200) begin
      tick(1);
      cyc++;
    end
    checkOutput("t1_done_cycle", cyc, 10);
    checkOutput("t1_busy_at_done", busy, 0);
    checkOutput("t1_xy_at_done", {pix_x, pix_y}, 0);
    tick(1);
    checkOutput("t1_done_pulse", done, 0);
    checkOutput("t1_pixels", popCount - p0, 8);
    checkOutput("t1_en_cycles", enCount, 8);
`ifdef CAM_CAPTURE_ERR_EN
    checkOutput("t1_err", err, 0);
`endif

    // Backpressure: FIFO fills, head holds
    pix_ready = 1'b0;
    enCount = 0;
    p0 = popCount;
    applyStimulus(8'h10);
    tick(8);
    checkOutput("t2_en_dropped", camera_en, 0);
    checkOutput("t2_en_beats", enCount, 4);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t2_head", {pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol}, {1'b1, 8'h10, 8'd0, 8'd0, 1'b1, 1'b0});
      tick(1);
    end
    pix_ready = 1'b1;
    waitDone(cyc);
    tick(1);
    checkOutput("t2_pixels", popCount - p0, 8);
    checkOutput("t2_en_total", enCount, 8);
    checkOutput("t2_sb_empty", sb.size(), 0);

    // Camera misses two beats mid-frame
    dropArm = 1'b1;
    dropLeft = 2;
    p0 = popCount;
    applyStimulus(8'h10);
    waitDone(cyc);
    tick(1);
    dropArm = 1'b0;
    checkOutput("t3_pixels", popCount - p0, 8);
    checkOutput("t3_drops_used", dropLeft, 0);
`ifdef CAM_CAPTURE_ERR_EN
    checkOutput("t3_err", err, 1);
`endif

    // Second start during capture is ignored
    p0 = popCount;
    applyStimulus(8'h10);
`ifdef CAM_CAPTURE_ERR_EN
    checkOutput("t4_err_cleared", err, 0);
`endif
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    waitDone(cyc);
    tick(6);
    checkOutput("t4_pixels", popCount - p0, 8);
    checkOutput("t4_idle", {busy, pix_valid, camera_en}, 0);

    // Reset mid-frame, then a fresh frame
    p0 = popCount;
    applyStimulus(8'h30);
    cyc = 0;
    while (popCount - p0 < 3 && cyc < 100) begin
      tick(1);
      cyc++;
    end
    checkOutput("t5_three_popped", popCount - p0, 3);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_outputs", {camera_en, busy, done, pix_valid}, 0);
    checkOutput("t5_rst_xy", {pix_x, pix_y}, 0);
    sb.delete();
    tick(1);
    rst_n = 1'b1;
    tick(1);
    p0 = popCount;
    applyStimulus(8'h40);
    waitDone(cyc);
    tick(1);
    checkOutput("t5_fresh_pixels", popCount - p0, 8);
    checkOutput("t5_sb_empty", sb.size(), 0);

    // Camera asserting valid while idle
    p0 = popCount;
    forceValid = 1'b1;
    tick(10);
    checkOutput("t6_no_valid", pix_valid, 0);
    checkOutput("t6_no_pixels", popCount - p0, 0);
`ifdef CAM_CAPTURE_ERR_EN
    checkOutput("t6_err", err, 0);
`endif
    forceValid = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
